// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: default widths,
// occupancy state encoding and the stall-counter saturation source value.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned CNT_W_MAX  = 64;

  // Occupancy state; the encoding equals the number of entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  // All-ones source; truncated to CNT_W to form the saturation value.
  localparam logic [CNT_W_MAX-1:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying one control and one data payload.
//   master: drives valid, ctrl, data; samples ready
//   slave : samples valid, ctrl, data; drives ready
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);

endinterface

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid + ctrl + data register.
//   clk, rst     : clock, synchronous active-high reset (zeroes everything)
//   load         : capture in_ctrl/in_data and mark valid
//   clear_ctrl   : invalidate and zero ctrl (bubble); data is kept
//   in_ctrl/data : payload to capture
//   valid/ctrl/data : registered entry contents
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Bubble beats load so a flush can never be overridden by a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear_ctrl) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, stall, flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
//   clk, rst     : clock, synchronous active-high reset
//   stall        : freeze the stage (no transfer on either side)
//   flush        : drop all held entries (bubble)
//   in_bus       : upstream handshake (slave side)
//   out_bus      : downstream handshake (master side)
//   occupancy    : entries held (0..2)
//   stall_cycles : saturating count of stalled cycles with occupancy > 0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  pipe_stage_reg_if.slave  in_bus,
  pipe_stage_reg_if.master out_bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_SAT_ALL);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
  logic              in_fire, out_fire;
  logic              main_load, main_from_skid, main_clear;
  logic              skid_load, skid_clear;
  occ_state_e        state;

  // The skid entry is only ever valid while the main entry is.
  always_comb begin
    state = ST_EMPTY;
    if (skid_valid)      state = ST_TWO;
    else if (main_valid) state = ST_ONE;
  end

  assign occupancy = 2'(state);

  // With the skid buffer, ready depends only on registered state and stall.
  assign in_bus.ready = ~rst & ~stall &
                        ((SKID != 0) ? ~skid_valid : (~main_valid | out_bus.ready));

  assign out_bus.valid = main_valid & ~stall;
  assign out_bus.ctrl  = out_bus.valid ? main_ctrl : '0;
  assign out_bus.data  = main_data;

  assign in_fire  = in_bus.valid & in_bus.ready;
  assign out_fire = out_bus.valid & out_bus.ready;

  // Entry load/clear decisions from occupancy and the two fires.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) main_load = 1'b1;
        end
        ST_ONE: begin
          if (in_fire && out_fire) main_load  = 1'b1;
          else if (in_fire)        skid_load  = (SKID != 0);
          else if (out_fire)       main_clear = 1'b1;
        end
        ST_TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_bus.ctrl;
  assign main_ld_data = main_from_skid ? skid_data : in_bus.data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear_ctrl (main_clear),
    .in_ctrl    (main_ld_ctrl),
    .in_data    (main_ld_data),
    .valid      (main_valid),
    .ctrl       (main_ctrl),
    .data       (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .clear_ctrl (skid_clear),
      .in_ctrl    (in_bus.ctrl),
      .in_data    (in_bus.data),
      .valid      (skid_valid),
      .ctrl       (skid_ctrl),
      .data       (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign unused_skid = skid_load | skid_clear;
    assign skid_valid  = 1'b0;
    assign skid_ctrl   = '0;
    assign skid_data   = '0;
  end

  // Saturating stall counter; never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (state != ST_EMPTY) && (stall_cycles != CNT_SAT)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
